pdm2pcm_interface: RTL and testbench

Front end of the PDM2PCM microphone path. Generates the microphone PDM clock from clk_i and resynchronises the microphone data line. Captures the left and right channel bits at the correct phase and presents each as a single-cycle `pdm_*_o`/`valid_*_o` strobe pair. Each strobe pair drives the `pdm_i`/`valid_i` inputs of one PDM decimator.

---
 rtl/pdm2pcm_pkg.sv | 20 ++
 rtl/pdm2pcm_clock_gen.sv | 60 ++++++
 rtl/pdm2pcm_interface.sv | 130 +++++++++++++
 tb/tb_pdm2pcm_interface.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm2pcm_pkg.sv
// Shared types and constants for the PDM2PCM microphone front end.
// The default wake-up length is also used by the top-level register map.
package pdm2pcm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAKEUP,
    RUN
  } state_e;

  localparam logic [7:0] MIN_DIVISOR = 8'd3;

  localparam int unsigned WAKEUP_PERIODS_DEFAULT = 4096;

  // Shorter half periods leave no room for the 2-cycle synchroniser before capture.
  function automatic logic [7:0] clamp_divisor(input logic [7:0] div);
    return (div < MIN_DIVISOR) ? MIN_DIVISOR : div;
  endfunction

endpackage

// File: rtl/pdm2pcm_clock_gen.sv
// Microphone clock generator: half-period counter, divisor register and pdm_clk_o.
// Registered output; rise/fall-pending pulses flag the wrap cycle before each edge.
module pdm2pcm_clock_gen
  import pdm2pcm_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       run_i,
  input  logic       load_i,
  input  logic [7:0] clock_divisor_i,
  output logic       pdm_clk_o,
  output logic       rise_pend_o,
  output logic       fall_pend_o
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] div_q, div_d;
  logic       clk_q, clk_d;
  logic       wrap;

  assign wrap = run_i && (cnt_q == div_q);

  // The divisor is only reloaded at an edge so a half period is never stretched or cut.
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    clk_d = clk_q;
    if (load_i) begin
      cnt_d = 8'd0;
      clk_d = 1'b0;
      div_d = clamp_divisor(clock_divisor_i);
    end else if (!run_i) begin
      cnt_d = 8'd0;
      clk_d = 1'b0;
    end else if (wrap) begin
      cnt_d = 8'd0;
      clk_d = ~clk_q;
      div_d = clamp_divisor(clock_divisor_i);
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= 8'd0;
      div_q <= 8'd0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      clk_q <= clk_d;
    end
  end

  assign pdm_clk_o   = clk_q;
  assign rise_pend_o = wrap && !clk_q;
  assign fall_pend_o = wrap && clk_q;

endmodule

// File: rtl/pdm2pcm_interface.sv
// PDM microphone front end: clock generation, data resync, wake-up and per-channel capture.
// Strobes appear the cycle after the wrap cycle, with the pdm_clk_o edge; no backpressure.
module pdm2pcm_interface
  import pdm2pcm_pkg::*;
#(
  parameter int unsigned WAKEUP_PERIODS = WAKEUP_PERIODS_DEFAULT,
  parameter int unsigned WAKEUP_WIDTH   = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic [7:0] clock_divisor_i,
  input  logic       stereo_i,
  input  logic       pdm_data_i,
  output logic       pdm_clk_o,
  output logic       pdm_left_o,
  output logic       valid_left_o,
  output logic       pdm_right_o,
  output logic       valid_right_o,
  output logic       ready_o
);

  localparam logic [WAKEUP_WIDTH-1:0] WAKE_LAST = WAKEUP_WIDTH'(WAKEUP_PERIODS - 1);

  state_e                  state_q, state_d;
  logic [WAKEUP_WIDTH-1:0] wake_q, wake_d;
  logic [1:0]              sync_q, sync_d;
  logic                    ready_q, ready_d;
  logic                    left_q, left_d;
  logic                    right_q, right_d;
  logic                    valid_left_q, valid_left_d;
  logic                    valid_right_q, valid_right_d;

  logic run, load;
  logic rise_pend, fall_pend;
  logic data_sync;

  assign run       = enable_i && (state_q != IDLE);
  assign load      = enable_i && (state_q == IDLE);
  assign sync_d    = {sync_q[0], pdm_data_i};
  assign data_sync = sync_q[1];

  pdm2pcm_clock_gen u_clock_gen (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .run_i           (run),
    .load_i          (load),
    .clock_divisor_i (clock_divisor_i),
    .pdm_clk_o       (pdm_clk_o),
    .rise_pend_o     (rise_pend),
    .fall_pend_o     (fall_pend)
  );

  always_comb begin
    state_d       = state_q;
    wake_d        = wake_q;
    ready_d       = ready_q;
    left_d        = left_q;
    right_d       = right_q;
    valid_left_d  = 1'b0;
    valid_right_d = 1'b0;
    case (state_q)
      IDLE: begin
        wake_d = '0;
        if (enable_i) state_d = WAKEUP;
      end
      WAKEUP: begin
        if (fall_pend) begin
          if (wake_q == WAKE_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
            wake_d  = '0;
          end else begin
            wake_d = wake_q + WAKEUP_WIDTH'(1);
          end
        end
      end
      RUN: begin
        // Left is driven by the mic during the high phase, right during the low phase.
        if (fall_pend) begin
          left_d       = data_sync;
          valid_left_d = 1'b1;
        end
        if (rise_pend && stereo_i) begin
          right_d       = data_sync;
          valid_right_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable_i) begin
      state_d       = IDLE;
      wake_d        = '0;
      ready_d       = 1'b0;
      left_d        = 1'b0;
      right_d       = 1'b0;
      valid_left_d  = 1'b0;
      valid_right_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      wake_q        <= '0;
      sync_q        <= 2'b00;
      ready_q       <= 1'b0;
      left_q        <= 1'b0;
      right_q       <= 1'b0;
      valid_left_q  <= 1'b0;
      valid_right_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wake_q        <= wake_d;
      sync_q        <= sync_d;
      ready_q       <= ready_d;
      left_q        <= left_d;
      right_q       <= right_d;
      valid_left_q  <= valid_left_d;
      valid_right_q <= valid_right_d;
    end
  end

  assign ready_o       = ready_q;
  assign pdm_left_o    = left_q;
  assign pdm_right_o   = right_q;
  assign valid_left_o  = valid_left_q;
  assign valid_right_o = valid_right_q;

endmodule

// File: tb/tb_pdm2pcm_interface.sv
// Bench for pdm2pcm_interface: a microphone model drives data per clock phase and
// queues the expected captured bits; strobes pop and compare against the queues.
module tb_pdm2pcm_interface;

  localparam int WAKE = 4;
  localparam int DIV  = 4;
  localparam int BUDGET = 2000;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       enable_i = 1'b0;
  logic [7:0] clock_divisor_i = 8'(DIV);
  logic       stereo_i = 1'b0;
  logic       pdm_data_i = 1'b0;
  logic       pdm_clk_o, pdm_left_o, valid_left_o, pdm_right_o, valid_right_o, ready_o;

  always #5 clk_i = ~clk_i;

  pdm2pcm_interface #(
    .WAKEUP_PERIODS (WAKE),
    .WAKEUP_WIDTH   (16)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .enable_i        (enable_i),
    .clock_divisor_i (clock_divisor_i),
    .stereo_i        (stereo_i),
    .pdm_data_i      (pdm_data_i),
    .pdm_clk_o       (pdm_clk_o),
    .pdm_left_o      (pdm_left_o),
    .valid_left_o    (valid_left_o),
    .pdm_right_o     (pdm_right_o),
    .valid_right_o   (valid_right_o),
    .ready_o         (ready_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int  cyc = 0;
  int  mic_falls = 0;
  int  n_left = 0, n_right = 0, n_edges = 0;
  int  last_left = -1, last_right = -1;
  int  last_edge = 0, half_len = 0;
  int  exp_per = 2 * (DIV + 1);
  bit  chk_per = 1'b0;
  bit  pat_mode = 1'b0;
  logic prev_clk = 1'b0;
  logic lbit = 1'b0, rbit = 1'b0;
  bit  exp_l_q[$];
  bit  exp_r_q[$];

  // Monitor and microphone model share one process so pushes and pops are ordered.
  initial forever begin
    @(negedge clk_i);
    cyc++;
    if (valid_left_o && valid_right_o) check("both_strobes", 1, 0);
    if (valid_left_o) begin
      n_left++;
      if (exp_l_q.size() == 0) check("left_unexpected", 1, 0);
      else check("left_data", pdm_left_o, exp_l_q.pop_front());
      if (chk_per && last_left >= 0) check("left_period", cyc - last_left, exp_per);
      if (chk_per && last_right >= 0) check("right_to_left", cyc - last_right, exp_per / 2);
      last_left = cyc;
    end
    if (valid_right_o) begin
      n_right++;
      if (exp_r_q.size() == 0) check("right_unexpected", 1, 0);
      else check("right_data", pdm_right_o, exp_r_q.pop_front());
      if (chk_per && last_right >= 0) check("right_period", cyc - last_right, exp_per);
      if (chk_per && last_left >= 0) check("left_to_right", cyc - last_left, exp_per / 2);
      last_right = cyc;
    end
    if (pdm_clk_o != prev_clk) begin
      n_edges++;
      half_len  = cyc - last_edge;
      last_edge = cyc;
      if (pdm_clk_o) begin
        lbit = pat_mode ? 1'b1 : ~lbit;
        pdm_data_i = lbit;
        if (mic_falls >= WAKE) exp_l_q.push_back(lbit);
      end else begin
        mic_falls++;
        rbit = pat_mode ? 1'b0 : 1'($urandom_range(0, 1));
        pdm_data_i = rbit;
        if (mic_falls >= WAKE && stereo_i) exp_r_q.push_back(rbit);
      end
    end
    prev_clk = pdm_clk_o;
  end

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic wait_level(input logic lvl, output int n);
    n = 0;
    while (pdm_clk_o !== lvl && n < BUDGET) begin
      step();
      n++;
    end
    if (n >= BUDGET) check("timeout_clk_level", 1, 0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready_o !== 1'b1 && n < BUDGET) begin
      step();
      n++;
    end
    if (n >= BUDGET) check("timeout_ready", 1, 0);
  endtask

  task automatic wait_edges(input int k);
    int target = n_edges + k;
    int n = 0;
    while (n_edges < target && n < BUDGET) begin
      step();
      n++;
    end
    if (n >= BUDGET) check("timeout_edges", 1, 0);
  endtask

  task automatic wait_left(input int target);
    int n = 0;
    while (n_left < target && n < BUDGET) begin
      step();
      n++;
    end
    if (n >= BUDGET) check("timeout_left", 1, 0);
  endtask

  task automatic wait_right(input int target);
    int n = 0;
    while (n_right < target && n < BUDGET) begin
      step();
      n++;
    end
    if (n >= BUDGET) check("timeout_right", 1, 0);
  endtask

  task automatic clear_model();
    exp_l_q.delete();
    exp_r_q.delete();
    mic_falls  = 0;
    last_left  = -1;
    last_right = -1;
  endtask

  // Enable/restart sequence: first rise is one IDLE cycle plus DIV+1 away, ready lands
  // on the WAKE-th fall, and nothing is strobed before it.
  task automatic check_wakeup(input string tag);
    int n;
    int strobes0 = n_left + n_right;
    wait_level(1'b1, n);
    check({tag, "_first_rise"}, n, DIV + 2);
    wait_ready(n);
    check({tag, "_ready_time"}, n, (DIV + 1) + 2 * (DIV + 1) * (WAKE - 1));
    check({tag, "_ready_on_fall"}, {pdm_clk_o, 31'(cyc - last_edge)}, 0);
    check({tag, "_wake_falls"}, mic_falls, WAKE);
    check({tag, "_no_early_strobe"}, n_left + n_right, strobes0);
  endtask

  initial begin
    int nl, nr, n;
    repeat (3) step();
    check("rst_outputs",
          {26'd0, pdm_clk_o, pdm_left_o, valid_left_o, pdm_right_o, valid_right_o, ready_o}, 0);
    rst_n_i = 1'b1;
    step();
    check("idle_clk_low", pdm_clk_o, 0);

    enable_i = 1'b1;
    check_wakeup("wake1");

    // Mono, left bit alternating every period.
    chk_per = 1'b1;
    exp_per = 2 * (DIV + 1);
    wait_left(n_left + 8);
    check("mono_right_none", n_right, 0);

    // Stereo: left 1 in the high phase, right 0 in the low phase.
    wait_level(1'b0, n);
    wait_level(1'b1, n);
    stereo_i = 1'b1;
    pat_mode = 1'b1;
    wait_right(n_right + 6);
    check("stereo_left_one", pdm_left_o, 1);
    check("stereo_right_zero", pdm_right_o, 0);

    // Divisor below the minimum behaves as 3.
    chk_per = 1'b0;
    clock_divisor_i = 8'd1;
    wait_edges(3);
    check("div1_half_a", half_len, 4);
    wait_edges(1);
    check("div1_half_b", half_len, 4);
    exp_per = 8;
    last_left = -1;
    last_right = -1;
    chk_per = 1'b1;
    wait_left(n_left + 3);

    // Divisor 4 -> 6 mid-half-period.
    chk_per = 1'b0;
    clock_divisor_i = 8'd4;
    wait_edges(3);
    wait_edges(1);
    repeat (2) step();
    clock_divisor_i = 8'd6;
    wait_edges(1);
    check("div_change_cur_half", half_len, 5);
    wait_edges(1);
    check("div_change_next_half", half_len, 7);
    exp_per = 14;
    last_left = -1;
    last_right = -1;
    chk_per = 1'b1;
    wait_left(n_left + 3);

    chk_per = 1'b0;
    clock_divisor_i = 8'(DIV);
    wait_edges(4);

    // Drop enable exactly on the wrap cycle of a left capture.
    wait_level(1'b0, n);
    wait_level(1'b1, n);
    repeat (DIV) step();
    enable_i = 1'b0;
    nl = n_left;
    nr = n_right;
    step();
    check("drop_clk_low", pdm_clk_o, 0);
    check("drop_ready_low", ready_o, 0);
    check("drop_strobe_suppressed", n_left, nl);
    repeat (40) step();
    check("drop_no_left", n_left, nl);
    check("drop_no_right", n_right, nr);
    clear_model();

    // Re-enable repeats the full wake-up.
    stereo_i = 1'b0;
    pat_mode = 1'b0;
    enable_i = 1'b1;
    check_wakeup("wake2");
    wait_left(n_left + 2);

    // Asynchronous reset in the middle of a high phase.
    wait_level(1'b0, n);
    wait_level(1'b1, n);
    repeat (2) step();
    check("pre_rst_clk_high", pdm_clk_o, 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("async_rst_outputs",
          {26'd0, pdm_clk_o, pdm_left_o, valid_left_o, pdm_right_o, valid_right_o, ready_o}, 0);
    step();
    clear_model();
    rst_n_i = 1'b1;
    check_wakeup("wake3");
    wait_left(n_left + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
